eq_band_sched: RTL
==================

# eq_band_sched

Time-multiplexed scheduler that shares a single `band_scale` instance across all equalizer bands. On each audio sample strobe it captures every band's pot setting and band-filtered sample. It issues them one band per cycle into the shared scaler pipeline, honouring the scaler's skewed pot/audio timing. It accumulates and saturates the scaled results into one 16-bit equalized output. It sits between the band filter bank and the output stage.

## Interface
- `NUM_BANDS`, default 5: number of bands sharing the scaler; legal range 2..8.
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `smpl_vld` input, 1 bit: one-cycle strobe; a new sample set is present on `pot_bus` and `band_audio`.
- `pot_bus` input, 12*NUM_BANDS bits: unsigned pot for each band; band i is at [12i+11:12i].
- `band_audio` input, 16*NUM_BANDS bits: signed band-filtered sample for each band; band i is at [16i+15:16i].
- `vol_pot` input, 12 bits: master volume pot; used only with `EQ_BAND_SCHED_VOLUME_EN`.
- `eq_out` output, 16 bits, signed: saturated equalized sample; held until the next result.
- `eq_vld` output, 1 bit: one-cycle pulse marking a new `eq_out`.
- `busy` output, 1 bit: a sample set is in progress.
- `ovr` output, 1 bit: one-cycle pulse; a `smpl_vld` arrived while busy and was dropped.

## Operation
- **Reset**
  - State goes to IDLE.
  - `eq_out`, `eq_vld`, `busy` and `ovr` are 0.
  - Capture registers, accumulator and index are 0.
  - The scaler is driven with pot=0 and audio=0.
- **FSM states:** IDLE, ISSUE, DRAIN, VOL (only with macro), DONE.
- **IDLE**
  - On `smpl_vld`, register all pots and samples, clear the accumulator and index, then go to ISSUE.
  - The inputs may change after the capture cycle.
- **ISSUE** (NUM_BANDS cycles): present pot[idx] to the scaler and increment idx.
- **Audio skew:** the scaler registers pot² first and samples audio one cycle later. The scheduler therefore presents audio[idx] one cycle after the matching pot, through a registered copy of idx.
- **DRAIN:** remains until the last band's scaled result has been accumulated.
- **Scaler idle inputs:** pot and audio are 0 whenever no band is being issued.
- **Accumulation**
  - Each 16-bit signed scaled result is sign-extended to 19 bits and added.
  - The final 19-bit sum saturates to 16 bits: above 32767 gives 16'h7FFF; below -32768 gives 16'h8000.
- **DONE**
  - Register the saturated result to `eq_out` and pulse `eq_vld`.
  - Return to IDLE in that same cycle.
  - A `smpl_vld` during the `eq_vld` cycle is accepted.
- **Overrun:** a `smpl_vld` while `busy`=1 is dropped; `ovr` pulses the next cycle and the current operation is unaffected.
- **Reset mid-operation:** aborts immediately, with no `eq_vld`; the next `smpl_vld` after reset is processed normally.

## Timing
- Cycle 0 is the cycle in which `smpl_vld` is high in IDLE.
- Band i:
  - pot presented in cycle 1+i;
  - audio presented in cycle 2+i;
  - scaled result accumulated at the end of cycle 3+i.
- `busy` is high from cycle 1 through the cycle before `eq_vld`.
- Without macro: `eq_vld` is high in cycle NUM_BANDS+3, which is cycle 8 for 5 bands.
- With macro: `eq_vld` is high in cycle NUM_BANDS+5, which is cycle 10 for 5 bands.
- Throughput is one sample set per NUM_BANDS+3 cycles, or NUM_BANDS+5 with the macro.

## Configuration
- **Macro:** `EQ_BAND_SCHED_VOLUME_EN`.
- **Defined:** the saturated band sum makes one extra pass through the shared scaler, in state VOL.
  - `vol_pot` is presented in cycle NUM_BANDS+2.
  - The sum is presented as audio in cycle NUM_BANDS+3.
  - The scaler's saturated output becomes `eq_out`.
- **Undefined:** VOL does not exist and `vol_pot` is ignored.

## Structure
- **Package `eq_pkg`:**
  - FSM state enum;
  - constant `EQ_ACC_W` = 19;
  - constant `EQ_POT_W` = 12;
  - constant `EQ_AUD_W` = 16;
  - saturation function from 19 to 16 bits.
- **Sub-module:** exactly one instance of the existing `band_scale`. It applies pot²>>12 gain, takes output bits [25:10], has 2 flop stages and saturates. No other sub-modules.

## Test plan
- **All bands, full gain:** NUM_BANDS=5, all pots 12'hFFF, all audio 1000 → each band gives 3998; `eq_out`=19990 with `eq_vld` in cycle 8.
- **Positive saturation:** all pots 12'hFFF, all audio 16'h7000 → each band saturates to 16'h7FFF; `eq_out`=16'h7FFF.
- **Negative saturation:** all pots 12'hFFF, all audio -20000 → `eq_out`=16'h8000.
- **Single band active:** only band 2 pot=12'hFFF with audio 1000, other pots 0 → `eq_out`=3998; confirms the pot/audio index skew.
- **Overrun and mid-operation reset:**
  - `smpl_vld` again in cycle 2 → `ovr` pulses in cycle 3 and `eq_out` reflects only the first set.
  - `rst_n` low in cycle 4 → all outputs 0 with no `eq_vld`; the next set produces the correct result.
- **Volume pass:** with `EQ_BAND_SCHED_VOLUME_EN`, use the full-gain stimulus above plus `vol_pot`=12'h400 → `eq_out`=4997 with `eq_vld` in cycle 10.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types, widths and the 19->16 bit saturation helper for the equalizer band scheduler.
// The VOL state exists only when EQ_BAND_SCHED_VOLUME_EN is defined.
package eq_pkg;

  localparam int EQ_ACC_W = 19;
  localparam int EQ_POT_W = 12;
  localparam int EQ_AUD_W = 16;

`ifdef EQ_BAND_SCHED_VOLUME_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_VOL   = 3'd3,
    ST_DONE  = 3'd4
  } eq_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd4
  } eq_state_e;
`endif

  function automatic logic signed [EQ_AUD_W-1:0] sat_acc(input logic signed [EQ_ACC_W-1:0] a);
    if (a > EQ_ACC_W'(32767))
      return 16'sh7FFF;
    else if (a < -EQ_ACC_W'(32768))
      return 16'sh8000;
    else
      return a[EQ_AUD_W-1:0];
  endfunction

endpackage

// File: rtl/band_scale.sv
// Two-stage band gain: registers pot^2>>12 first, then multiplies by audio presented
// one cycle later and saturates product bits [25:10] to a signed 16-bit result.
module band_scale
  import eq_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [EQ_POT_W-1:0]         pot,
  input  logic signed [EQ_AUD_W-1:0]  audio,
  output logic signed [EQ_AUD_W-1:0]  scaled
);

  logic [2*EQ_POT_W-1:0] pot_sq_p0;
  logic [EQ_POT_W-1:0]   gain_p1;
  logic signed [28:0]    prod_p1;

  function automatic logic signed [EQ_AUD_W-1:0] sat_prod(input logic signed [28:0] p);
    if ((p[28:25] == 4'b0000) || (p[28:25] == 4'b1111))
      return p[25:10];
    else if (p[28])
      return 16'sh8000;
    else
      return 16'sh7FFF;
  endfunction

  assign pot_sq_p0 = pot * pot;
  assign prod_p1   = $signed({1'b0, gain_p1}) * audio;

  // p0 -> p1: squared pot becomes the gain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gain_p1 <= '0;
    else
      gain_p1 <= pot_sq_p0[2*EQ_POT_W-1:EQ_POT_W];
  end

  // p1 -> p2: gain times the (one cycle later) audio, saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      scaled <= '0;
    else
      scaled <= sat_prod(prod_p1);
  end

endmodule

// File: rtl/eq_band_sched.sv
// Time-multiplexes one band_scale across NUM_BANDS bands and accumulates a saturated sum.
// Optional master-volume pass through the same scaler: define EQ_BAND_SCHED_VOLUME_EN.
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            smpl_vld,
  input  logic [EQ_POT_W*NUM_BANDS-1:0]   pot_bus,
  input  logic [EQ_AUD_W*NUM_BANDS-1:0]   band_audio,
  input  logic [EQ_POT_W-1:0]             vol_pot,
  output logic signed [EQ_AUD_W-1:0]      eq_out,
  output logic                            eq_vld,
  output logic                            busy,
  output logic                            ovr
);

  localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  eq_state_e state, state_nxt;

  logic [EQ_POT_W-1:0]        pot_cap [NUM_BANDS];
  logic signed [EQ_AUD_W-1:0] aud_cap [NUM_BANDS];
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           aud_idx_p1;
  logic                       vld_p1, last_p1;
  logic                       vld_p2, last_p2;
  logic signed [EQ_ACC_W-1:0] acc;
  logic signed [EQ_ACC_W-1:0] acc_sum;
  logic [EQ_POT_W-1:0]        scl_pot;
  logic signed [EQ_AUD_W-1:0] scl_aud;
  logic signed [EQ_AUD_W-1:0] scl_out;
  logic                       accept;

`ifdef EQ_BAND_SCHED_VOLUME_EN
  logic vol_ph;
`else
  logic unused_vol;
  assign unused_vol = ^vol_pot;
`endif

  // DONE doubles as an idle state so a strobe in the eq_vld cycle is taken
  assign accept  = smpl_vld && ((state == ST_IDLE) || (state == ST_DONE));
  assign acc_sum = acc + $signed({{(EQ_ACC_W-EQ_AUD_W){scl_out[EQ_AUD_W-1]}}, scl_out});

`ifdef EQ_BAND_SCHED_VOLUME_EN
  assign busy = (state == ST_ISSUE) || (state == ST_DRAIN) || (state == ST_VOL);
`else
  assign busy = (state == ST_ISSUE) || (state == ST_DRAIN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: state_nxt = smpl_vld ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:         if (idx == LAST_IDX) state_nxt = ST_DRAIN;
`ifdef EQ_BAND_SCHED_VOLUME_EN
      ST_DRAIN:         if (vld_p2 && last_p2) state_nxt = ST_VOL;
      ST_VOL:           if (vol_ph) state_nxt = ST_DONE;
`else
      ST_DRAIN:         if (vld_p2 && last_p2) state_nxt = ST_DONE;
`endif
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Scaler inputs: pot in the issue cycle, audio one cycle later via the registered index
  always_comb begin
    scl_pot = '0;
    scl_aud = '0;
    if (state == ST_ISSUE)
      scl_pot = pot_cap[idx];
    if (vld_p1)
      scl_aud = aud_cap[aud_idx_p1];
`ifdef EQ_BAND_SCHED_VOLUME_EN
    if ((state == ST_DRAIN) && last_p2)
      scl_pot = vol_pot;
    if ((state == ST_VOL) && !vol_ph)
      scl_aud = sat_acc(acc);
`endif
  end

  band_scale u_band_scale (
    .clk    (clk),
    .rst_n  (rst_n),
    .pot    (scl_pot),
    .audio  (scl_aud),
    .scaled (scl_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        pot_cap[b] <= '0;
        aud_cap[b] <= '0;
      end
      idx        <= '0;
      aud_idx_p1 <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      vld_p2     <= 1'b0;
      last_p2    <= 1'b0;
      acc        <= '0;
      eq_out     <= '0;
      eq_vld     <= 1'b0;
      ovr        <= 1'b0;
`ifdef EQ_BAND_SCHED_VOLUME_EN
      vol_ph     <= 1'b0;
`endif
    end else begin
      eq_vld <= 1'b0;
      ovr    <= smpl_vld && busy;

      if (accept) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          pot_cap[b] <= pot_bus[b*EQ_POT_W +: EQ_POT_W];
          aud_cap[b] <= band_audio[b*EQ_AUD_W +: EQ_AUD_W];
        end
        acc <= '0;
        idx <= '0;
      end

      if (state == ST_ISSUE)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;

      // p0 -> p1: pot issued, audio follows with this index
      vld_p1     <= (state == ST_ISSUE);
      aud_idx_p1 <= idx;
      last_p1    <= (state == ST_ISSUE) && (idx == LAST_IDX);

      // p1 -> p2: scaler output for this band is valid
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;

      if (vld_p2)
        acc <= acc_sum;

`ifdef EQ_BAND_SCHED_VOLUME_EN
      if (state == ST_VOL) begin
        vol_ph <= ~vol_ph;
        if (vol_ph) begin
          eq_out <= scl_out;
          eq_vld <= 1'b1;
        end
      end
`else
      if (vld_p2 && last_p2) begin
        eq_out <= sat_acc(acc_sum);
        eq_vld <= 1'b1;
      end
`endif
    end
  end

endmodule
